// File: rtl/alarm_register_bank.sv
// alarm_register_bank
//   Holds DAYS alarm-time registers (WIDTH bits each) with one arm bit per day
//   and one indexed combinational read port. On each minute strobe the current
//   day's alarm is compared against the current time. A ring / snooze /
//   dismiss state machine is driven from that comparison.
//
//   Optional feature: define ALARM_TIMEOUT_EN to auto-stop ringing after
//   RING_MIN minute ticks. Without it, ringing lasts until Dismiss, Snooze
//   or Clr.
//
// Ports
//   Clk       in   clock, rising edge
//   Clr       in   synchronous reset, active-low
//   LD_R      in   write enable
//   STO       in   write index (writes with STO >= DAYS are dropped)
//   data      in   alarm time to store
//   Arm_In    in   arm bit stored together with data
//   RD_SEL    in   read index
//   Q_rd      out  register[RD_SEL], or 0 when RD_SEL >= DAYS
//   Armed     out  arm bits, bit i = day i
//   Cur_Day   in   current day index
//   Cur_Time  in   current time, sampled on Min_Tick
//   Min_Tick  in   one-cycle pulse per minute
//   Snooze    in   snooze request pulse
//   Dismiss   in   dismiss request pulse
//   Alarm     out  high while ringing (registered)
//   Snoozing  out  high while snoozing (registered)
//   Alarm_Day out  day index of the current/last alarm event
module alarm_register_bank #(
    parameter int DAYS       = 7,
    parameter int WIDTH      = 13,
    parameter int SNOOZE_MIN = 9,
    parameter int MAX_SNOOZE = 3,
    parameter int RING_MIN   = 5,
    localparam int SW        = $clog2(DAYS)
) (
    input  logic             Clk,
    input  logic             Clr,
    input  logic             LD_R,
    input  logic [SW-1:0]    STO,
    input  logic [WIDTH-1:0] data,
    input  logic             Arm_In,
    input  logic [SW-1:0]    RD_SEL,
    output logic [WIDTH-1:0] Q_rd,
    output logic [DAYS-1:0]  Armed,
    input  logic [SW-1:0]    Cur_Day,
    input  logic [WIDTH-1:0] Cur_Time,
    input  logic             Min_Tick,
    input  logic             Snooze,
    input  logic             Dismiss,
    output logic             Alarm,
    output logic             Snoozing,
    output logic [SW-1:0]    Alarm_Day
);

    localparam int SNZ_W = $clog2(SNOOZE_MIN + 1);
    // Keep the snooze-count register at least 1 bit even when MAX_SNOOZE = 0.
    localparam int NUM_W = (MAX_SNOOZE < 1) ? 1 : $clog2(MAX_SNOOZE + 1);

    localparam logic [SW:0]       DAYS_W   = (SW+1)'(DAYS);
    localparam logic [SNZ_W-1:0]  SNZ_LOAD = SNZ_W'(SNOOZE_MIN);
    localparam logic [NUM_W-1:0]  NUM_MAX  = NUM_W'(MAX_SNOOZE);

    typedef enum logic [1:0] {S_IDLE, S_RINGING, S_SNOOZING} state_e;

    logic [DAYS-1:0][WIDTH-1:0] regs_q;
    logic [DAYS-1:0]            armed_q;
    state_e                     state_q, state_d;
    logic [SW-1:0]              day_q, day_d;
    logic [SNZ_W-1:0]           snz_cnt_q, snz_cnt_d;
    logic [NUM_W-1:0]           snz_num_q, snz_num_d;
    logic                       alarm_q, snoozing_q;
    logic                       sto_ok, rd_ok, day_ok, match, snooze_ok;

`ifdef ALARM_TIMEOUT_EN
    localparam int               RING_W    = $clog2(RING_MIN + 1);
    localparam logic [RING_W-1:0] RING_LAST = RING_W'(RING_MIN - 1);
    logic [RING_W-1:0]           ring_cnt_q, ring_cnt_d;
`endif

    assign sto_ok = ({1'b0, STO}     < DAYS_W);
    assign rd_ok  = ({1'b0, RD_SEL}  < DAYS_W);
    assign day_ok = ({1'b0, Cur_Day} < DAYS_W);

    // Register file. Reads see the pre-edge contents, so a same-cycle write
    // never disturbs the match compare below.
    always_ff @(posedge Clk) begin
        if (!Clr) begin
            regs_q  <= '0;
            armed_q <= '0;
        end else if (LD_R && sto_ok) begin
            regs_q[STO]  <= data;
            armed_q[STO] <= Arm_In;
        end
    end

    assign Q_rd  = rd_ok ? regs_q[RD_SEL] : '0;
    assign Armed = armed_q;

    assign match     = Min_Tick && day_ok && armed_q[Cur_Day] &&
                       (regs_q[Cur_Day] == Cur_Time);
    assign snooze_ok = Snooze && (snz_num_q < NUM_MAX);

    always_comb begin
        state_d   = state_q;
        day_d     = day_q;
        snz_cnt_d = snz_cnt_q;
        snz_num_d = snz_num_q;
`ifdef ALARM_TIMEOUT_EN
        ring_cnt_d = ring_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (match) begin
                    state_d   = S_RINGING;
                    day_d     = Cur_Day;
                    snz_num_d = '0;
`ifdef ALARM_TIMEOUT_EN
                    ring_cnt_d = '0;
`endif
                end
            end
            S_RINGING: begin
                if (Dismiss) begin
                    state_d = S_IDLE;
                end else if (snooze_ok) begin
                    state_d   = S_SNOOZING;
                    snz_cnt_d = SNZ_LOAD;
                    snz_num_d = snz_num_q + NUM_W'(1);
                end
`ifdef ALARM_TIMEOUT_EN
                else if (Min_Tick) begin
                    if (ring_cnt_q == RING_LAST) state_d = S_IDLE;
                    else                         ring_cnt_d = ring_cnt_q + RING_W'(1);
                end
`endif
            end
            S_SNOOZING: begin
                if (Dismiss) begin
                    state_d = S_IDLE;
                end else if (Min_Tick) begin
                    if (snz_cnt_q == SNZ_W'(1)) begin
                        state_d   = S_RINGING;
                        snz_cnt_d = '0;
`ifdef ALARM_TIMEOUT_EN
                        ring_cnt_d = '0;
`endif
                    end else begin
                        snz_cnt_d = snz_cnt_q - SNZ_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are flopped from the next state so they change on the same
    // edge as the state register.
    always_ff @(posedge Clk) begin
        if (!Clr) begin
            state_q    <= S_IDLE;
            day_q      <= '0;
            snz_cnt_q  <= '0;
            snz_num_q  <= '0;
            alarm_q    <= 1'b0;
            snoozing_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            day_q      <= day_d;
            snz_cnt_q  <= snz_cnt_d;
            snz_num_q  <= snz_num_d;
            alarm_q    <= (state_d == S_RINGING);
            snoozing_q <= (state_d == S_SNOOZING);
        end
    end

`ifdef ALARM_TIMEOUT_EN
    always_ff @(posedge Clk) begin
        if (!Clr) ring_cnt_q <= '0;
        else      ring_cnt_q <= ring_cnt_d;
    end
`endif

    assign Alarm     = alarm_q;
    assign Snoozing  = snoozing_q;
    assign Alarm_Day = day_q;

endmodule

// File: tb/tb_alarm_register_bank.sv
// Directed bench for alarm_register_bank with default parameters
// (DAYS=7, WIDTH=13, SNOOZE_MIN=9, MAX_SNOOZE=3, RING_MIN=5).
module tb_alarm_register_bank;

    logic        Clk = 1'b0;
    logic        Clr, LD_R, Arm_In, Min_Tick, Snooze, Dismiss;
    logic [2:0]  STO, RD_SEL, Cur_Day, Alarm_Day;
    logic [12:0] data, Cur_Time, Q_rd;
    logic [6:0]  Armed;
    logic        Alarm, Snoozing;

    int errs   = 0;
    int checks = 0;

    alarm_register_bank #(
        .DAYS(7), .WIDTH(13), .SNOOZE_MIN(9), .MAX_SNOOZE(3), .RING_MIN(5)
    ) dut (
        .Clk(Clk), .Clr(Clr), .LD_R(LD_R), .STO(STO), .data(data), .Arm_In(Arm_In),
        .RD_SEL(RD_SEL), .Q_rd(Q_rd), .Armed(Armed), .Cur_Day(Cur_Day),
        .Cur_Time(Cur_Time), .Min_Tick(Min_Tick), .Snooze(Snooze), .Dismiss(Dismiss),
        .Alarm(Alarm), .Snoozing(Snoozing), .Alarm_Day(Alarm_Day)
    );

    always #5 Clk = ~Clk;

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic wr(input int idx, input logic [12:0] d, input logic arm);
        LD_R = 1'b1; STO = idx[2:0]; data = d; Arm_In = arm;
        cyc();
        LD_R = 1'b0;
    endtask

    task automatic tick_pulse();
        Min_Tick = 1'b1;
        cyc();
        Min_Tick = 1'b0;
    endtask

    task automatic trigger(input logic [12:0] t);
        Cur_Day = 3'd3; Cur_Time = t;
        tick_pulse();
        Cur_Time = 13'h0;
    endtask

    task automatic dismiss_pulse();
        Dismiss = 1'b1;
        cyc();
        Dismiss = 1'b0;
    endtask

    task automatic test_reset();
        Clr = 1'b0;
        cyc(); cyc();
        Clr = 1'b1;
        RD_SEL = 3'd3;
        #0;
        checks++; if (Alarm !== 1'b0)     begin errs++; $display("FAIL reset_alarm: got %b want 0", Alarm); end
        checks++; if (Snoozing !== 1'b0)  begin errs++; $display("FAIL reset_snoozing: got %b want 0", Snoozing); end
        checks++; if (Armed !== 7'h00)    begin errs++; $display("FAIL reset_armed: got %b want 0000000", Armed); end
        checks++; if (Alarm_Day !== 3'd0) begin errs++; $display("FAIL reset_day: got %0d want 0", Alarm_Day); end
        checks++; if (Q_rd !== 13'h0)     begin errs++; $display("FAIL reset_q: got %h want 0000", Q_rd); end
    endtask

    task automatic test_write_read();
        // Write is not visible before the edge.
        LD_R = 1'b1; STO = 3'd5; data = 13'h0155; Arm_In = 1'b0; RD_SEL = 3'd5;
        #1;
        checks++; if (Q_rd !== 13'h0) begin errs++; $display("FAIL wr_before_edge: got %h want 0000", Q_rd); end
        cyc();
        LD_R = 1'b0;
        checks++; if (Q_rd !== 13'h0155) begin errs++; $display("FAIL wr_after_edge: got %h want 0155", Q_rd); end
        wr(3, 13'h0A1E, 1'b1);
        RD_SEL = 3'd3; #1;
        checks++; if (Q_rd !== 13'h0A1E)  begin errs++; $display("FAIL wr_day3: got %h want 0a1e", Q_rd); end
        checks++; if (Armed !== 7'b0001000) begin errs++; $display("FAIL wr_armed: got %b want 0001000", Armed); end
        wr(7, 13'h1FFF, 1'b1);
        checks++; if (Armed !== 7'b0001000) begin errs++; $display("FAIL wr_sto7_armed: got %b want 0001000", Armed); end
        checks++; if (Q_rd !== 13'h0A1E)    begin errs++; $display("FAIL wr_sto7_day3: got %h want 0a1e", Q_rd); end
        RD_SEL = 3'd7; #1;
        checks++; if (Q_rd !== 13'h0) begin errs++; $display("FAIL rd_sel7: got %h want 0000", Q_rd); end
    endtask

    task automatic test_match();
        trigger(13'h0A1F);
        checks++; if (Alarm !== 1'b0) begin errs++; $display("FAIL match_wrong_time: got %b want 0", Alarm); end
        wr(3, 13'h0A1E, 1'b0);
        trigger(13'h0A1E);
        checks++; if (Alarm !== 1'b0) begin errs++; $display("FAIL match_disarmed: got %b want 0", Alarm); end
        wr(3, 13'h0A1E, 1'b1);
        trigger(13'h0A1E);
        checks++; if (Alarm !== 1'b1)     begin errs++; $display("FAIL match_alarm: got %b want 1", Alarm); end
        checks++; if (Alarm_Day !== 3'd3) begin errs++; $display("FAIL match_day: got %0d want 3", Alarm_Day); end
        dismiss_pulse();
        checks++; if (Alarm !== 1'b0) begin errs++; $display("FAIL match_dismiss: got %b want 0", Alarm); end
    endtask

    task automatic test_snooze();
        trigger(13'h0A1E);
        for (int r = 1; r <= 3; r++) begin
            Snooze = 1'b1; cyc(); Snooze = 1'b0;
            checks++; if (Alarm !== 1'b0 || Snoozing !== 1'b1) begin errs++; $display("FAIL snooze_enter%0d: got alarm=%b snz=%b want 0 1", r, Alarm, Snoozing); end
            Snooze = 1'b1; cyc(); Snooze = 1'b0;  // ignored while snoozing
            for (int t = 0; t < 8; t++) tick_pulse();
            checks++; if (Alarm !== 1'b0 || Snoozing !== 1'b1) begin errs++; $display("FAIL snooze_8ticks%0d: got alarm=%b snz=%b want 0 1", r, Alarm, Snoozing); end
            tick_pulse();
            checks++; if (Alarm !== 1'b1 || Snoozing !== 1'b0) begin errs++; $display("FAIL snooze_rering%0d: got alarm=%b snz=%b want 1 0", r, Alarm, Snoozing); end
        end
        Snooze = 1'b1; cyc(); Snooze = 1'b0;
        checks++; if (Alarm !== 1'b1 || Snoozing !== 1'b0) begin errs++; $display("FAIL snooze_max: got alarm=%b snz=%b want 1 0", Alarm, Snoozing); end
        dismiss_pulse();
        checks++; if (Alarm !== 1'b0) begin errs++; $display("FAIL snooze_dismiss: got %b want 0", Alarm); end
    endtask

    task automatic test_priority();
        trigger(13'h0A1E);
        Snooze = 1'b1; Dismiss = 1'b1; cyc(); Snooze = 1'b0; Dismiss = 1'b0;
        checks++; if (Alarm !== 1'b0 || Snoozing !== 1'b0) begin errs++; $display("FAIL prio_snz_dis: got alarm=%b snz=%b want 0 0", Alarm, Snoozing); end
        trigger(13'h0A1E);
        Snooze = 1'b1; cyc(); Snooze = 1'b0;
        Dismiss = 1'b1; Min_Tick = 1'b1; cyc(); Dismiss = 1'b0; Min_Tick = 1'b0;
        checks++; if (Alarm !== 1'b0 || Snoozing !== 1'b0) begin errs++; $display("FAIL prio_dis_snoozing: got alarm=%b snz=%b want 0 0", Alarm, Snoozing); end
        // Rewrite day3 in the match cycle: the compare uses the old value.
        LD_R = 1'b1; STO = 3'd3; data = 13'h0B00; Arm_In = 1'b1;
        Cur_Day = 3'd3; Cur_Time = 13'h0A1E; Min_Tick = 1'b1;
        cyc();
        LD_R = 1'b0; Min_Tick = 1'b0; Cur_Time = 13'h0;
        RD_SEL = 3'd3; #1;
        checks++; if (Alarm !== 1'b1)    begin errs++; $display("FAIL prio_old_value: got %b want 1", Alarm); end
        checks++; if (Q_rd !== 13'h0B00) begin errs++; $display("FAIL prio_new_value: got %h want 0b00", Q_rd); end
        // A match on another day while ringing does not re-trigger.
        wr(2, 13'h0222, 1'b1);
        Cur_Day = 3'd2; Cur_Time = 13'h0222; tick_pulse(); Cur_Time = 13'h0;
        checks++; if (Alarm !== 1'b1 || Alarm_Day !== 3'd3) begin errs++; $display("FAIL prio_no_retrigger: got alarm=%b day=%0d want 1 3", Alarm, Alarm_Day); end
        dismiss_pulse();
    endtask

    task automatic test_timeout();
        trigger(13'h0B00);
        checks++; if (Alarm !== 1'b1) begin errs++; $display("FAIL timeout_start: got %b want 1", Alarm); end
`ifdef ALARM_TIMEOUT_EN
        for (int t = 0; t < 4; t++) tick_pulse();
        checks++; if (Alarm !== 1'b1) begin errs++; $display("FAIL timeout_4ticks: got %b want 1", Alarm); end
        tick_pulse();
        checks++; if (Alarm !== 1'b0 || Snoozing !== 1'b0) begin errs++; $display("FAIL timeout_5ticks: got alarm=%b snz=%b want 0 0", Alarm, Snoozing); end
`else
        for (int t = 0; t < 20; t++) tick_pulse();
        checks++; if (Alarm !== 1'b1) begin errs++; $display("FAIL no_timeout_20ticks: got %b want 1", Alarm); end
        dismiss_pulse();
`endif
    endtask

    task automatic test_reset_mid();
        trigger(13'h0B00);
        checks++; if (Alarm !== 1'b1) begin errs++; $display("FAIL midrst_ring: got %b want 1", Alarm); end
        Clr = 1'b0; cyc(); Clr = 1'b1;
        RD_SEL = 3'd3; #1;
        checks++; if (Alarm !== 1'b0)     begin errs++; $display("FAIL midrst_alarm: got %b want 0", Alarm); end
        checks++; if (Armed !== 7'h00)    begin errs++; $display("FAIL midrst_armed: got %b want 0000000", Armed); end
        checks++; if (Q_rd !== 13'h0)     begin errs++; $display("FAIL midrst_day3: got %h want 0000", Q_rd); end
        checks++; if (Alarm_Day !== 3'd0) begin errs++; $display("FAIL midrst_day: got %0d want 0", Alarm_Day); end
        RD_SEL = 3'd2; #1;
        checks++; if (Q_rd !== 13'h0)     begin errs++; $display("FAIL midrst_day2: got %h want 0000", Q_rd); end
    endtask

    initial begin
        Clr = 1'b0; LD_R = 1'b0; STO = '0; data = '0; Arm_In = 1'b0; RD_SEL = '0;
        Cur_Day = '0; Cur_Time = '0; Min_Tick = 1'b0; Snooze = 1'b0; Dismiss = 1'b0;
        test_reset();
        test_write_read();
        test_match();
        test_snooze();
        test_priority();
        test_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/alarm_register_bank.md
Name: alarm_register_bank

Overview:
Parametrised successor to the per-day alarm-time register set. It holds DAYS alarm registers of WIDTH bits, each with its own arm bit, and exposes one indexed read port. On each minute strobe it compares the current day's alarm with the current time and runs a ring/snooze/dismiss state machine. It sits between the alarm-set UI datapath and the buzzer/display logic of the alarm clock.

Parameters:
DAYS, 7, number of alarm registers (one per day), 2..16
WIDTH, 13, alarm/time word width
SNOOZE_MIN, 9, minute ticks from Snooze until re-ring, >=1
MAX_SNOOZE, 3, maximum snoozes accepted per alarm event, >=0
RING_MIN, 5, minute ticks before auto-stop (only with ALARM_TIMEOUT_EN), >=1

Ports:
Clk  in  1  clock, rising edge
Clr  in  1  synchronous reset, active-low
LD_R  in  1  write enable
STO  in  SW=$clog2(DAYS)  write index
data  in  WIDTH  alarm time to store
Arm_In  in  1  arm bit written with data
RD_SEL  in  SW  read index
Q_rd  out  WIDTH  register[RD_SEL], combinational
Armed  out  DAYS  arm bits, bit i = day i
Cur_Day  in  SW  current day index
Cur_Time  in  WIDTH  current time, valid on Min_Tick cycle
Min_Tick  in  1  one-cycle pulse per minute
Snooze  in  1  snooze request, one-cycle pulse
Dismiss  in  1  dismiss request, one-cycle pulse
Alarm  out  1  high while ringing (registered)
Snoozing  out  1  high while in SNOOZING (registered)
Alarm_Day  out  SW  day index of current/last alarm event

Behaviour:
- Reset (Clr=0 at rising edge): all registers 0, Armed 0, state IDLE, Alarm 0, Snoozing 0, Alarm_Day 0, snooze counter 0, snooze count 0, ring counter 0. Clr has priority over all inputs. Reset mid-ring drops Alarm at that edge.
- Write: LD_R=1 and STO<DAYS -> reg[STO]<=data, Armed[STO]<=Arm_In at the edge. STO>=DAYS -> no write. A write takes effect for reads the cycle after the edge.
- Read: Q_rd = reg[RD_SEL]. RD_SEL>=DAYS -> 0.
- Match: Min_Tick=1, Cur_Day<DAYS, Armed[Cur_Day]=1 and reg[Cur_Day]==Cur_Time. Compares pre-write contents when LD_R targets the same register in the same cycle.
- States:
  - IDLE: on match -> RINGING; Alarm=1 from the next cycle; Alarm_Day<=Cur_Day; snooze count<=0; ring counter<=0.
  - RINGING: Dismiss -> IDLE. Otherwise Snooze with snooze count<MAX_SNOOZE -> SNOOZING, snooze counter<=SNOOZE_MIN, snooze count+1. Snooze with count==MAX_SNOOZE is ignored and the state stays RINGING. Dismiss and Snooze in the same cycle: Dismiss wins.
  - SNOOZING: Alarm=0, Snoozing=1. Each Min_Tick decrements the snooze counter. A Min_Tick when the counter is 1 -> RINGING (counter 0, ring counter 0). Dismiss -> IDLE and has priority over the tick. Snooze is ignored.
- While RINGING or SNOOZING, new matches are ignored (no re-trigger, Alarm_Day held). Writes and disarms of any day, including Alarm_Day, do not affect the active event.
- Compare is equality on the full WIDTH bits; there is no arithmetic on time values.

Optional Feature:
- ALARM_TIMEOUT_EN defined:
  - In RINGING, each Min_Tick increments the ring counter.
  - When a Min_Tick arrives with the counter at RING_MIN-1, the state goes to IDLE (auto-stop) and Alarm drops at that edge.
  - Dismiss/Snooze in the same cycle take priority over timeout.
- ALARM_TIMEOUT_EN undefined: no ring counter; RINGING persists until Dismiss, Snooze or Clr.

Test Plan:
- Reset/write/read: Clr=0 2 cycles, then write day3=13'h0A1E armed -> Q_rd(RD_SEL=3)=13'h0A1E, Armed=7'b0001000. Write STO=7 -> no change. RD_SEL=7 -> Q_rd=0.
- Match: day3 armed, Cur_Day=3, Cur_Time=13'h0A1E, Min_Tick -> Alarm=1 next cycle, Alarm_Day=3. Same case with day3 disarmed or time 13'h0A1F -> Alarm stays 0.
- Snooze: while ringing, Snooze -> Alarm=0, Snoozing=1. After 9 Min_Ticks -> Alarm=1. The 4th Snooze with MAX_SNOOZE=3 is ignored and Alarm stays 1.
- Priority: Snooze+Dismiss in the same cycle -> IDLE, Alarm=0, Snoozing=0. Dismiss during SNOOZING -> IDLE. LD_R rewrite of day3 in the match cycle -> match uses the old value.
- Timeout (ALARM_TIMEOUT_EN, RING_MIN=5): ring with no input -> Alarm falls at the edge of the 5th Min_Tick. Without the macro -> Alarm still 1 after 20 ticks.
- Reset mid-event: Clr=0 while RINGING -> Alarm=0, Armed=0, all regs 0 after the edge.
